mnacidpro_ctrl: RTL and testbench

MNACIDPRO_CTRL -- requirements
Module: mnacidpro_ctrl

---
 rtl/mnacidpro_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_mnacidpro_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mnacidpro_ctrl.sv
// Sequencer for a microfluidic nucleic-acid extraction cartridge: valve and peristaltic pump control.
// Optional build macro MNACIDPRO_CTRL_WASH2_EN adds a second SETTLE+WASH pass before ELUTE.
module mnacidpro_ctrl #(
    parameter int unsigned PUMP_DIV   = 4,
    parameter int unsigned LYSIS_CYC  = 64,
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned WASH_CYC   = 32,
    parameter int unsigned ELUTE_CYC  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       pump_dir,
    output logic       lysis_ctl,
    output logic       wash_ctl,
    output logic       elute_ctl,
    output logic       horiz_ctl,
    output logic       vertical_ctl,
    output logic       loop_exit_ctl,
    output logic       bead_vtl_ctl,
    output logic       bead_trap_ctl,
    output logic       collection_ctl,
    output logic       dead_end_ctl,
    output logic       pump1,
    output logic       pump2,
    output logic       pump3,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LYSIS  = 3'd1,
        S_SETTLE = 3'd2,
        S_WASH   = 3'd3,
        S_ELUTE  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam int V_LYSIS      = 0;
    localparam int V_WASH       = 1;
    localparam int V_ELUTE      = 2;
    localparam int V_HORIZ      = 3;
    localparam int V_VERTICAL   = 4;
    localparam int V_LOOP_EXIT  = 5;
    localparam int V_BEAD_VTL   = 6;
    localparam int V_BEAD_TRAP  = 7;
    localparam int V_COLLECTION = 8;
    localparam int V_DEAD_END   = 9;

    localparam logic [15:0] PUMP_LAST = 16'(PUMP_DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  phase_q, phase_d;
    logic [9:0]  valve_q, valve_d;
    logic [2:0]  pump_q, pump_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        aborted_q, aborted_d;
`ifdef MNACIDPRO_CTRL_WASH2_EN
    logic        wash_pass_q, wash_pass_d;
`endif

    function automatic logic [15:0] state_len(input state_t s);
        case (s)
            S_LYSIS:  state_len = 16'(LYSIS_CYC);
            S_SETTLE: state_len = 16'(SETTLE_CYC);
            S_WASH:   state_len = 16'(WASH_CYC);
            S_ELUTE:  state_len = 16'(ELUTE_CYC);
            default:  state_len = 16'd1;
        endcase
    endfunction

    function automatic logic is_pumping(input state_t s);
        is_pumping = (s == S_LYSIS) || (s == S_WASH) || (s == S_ELUTE);
    endfunction

    // Set bits mark valves that are vented (open) in the given state.
    function automatic logic [9:0] open_mask(input state_t s);
        logic [9:0] m;
        m = '0;
        case (s)
            S_LYSIS: begin
                m[V_LYSIS]     = 1'b1;
                m[V_HORIZ]     = 1'b1;
                m[V_LOOP_EXIT] = 1'b1;
            end
            S_SETTLE: begin
                m[V_BEAD_VTL]  = 1'b1;
                m[V_VERTICAL]  = 1'b1;
            end
            S_WASH: begin
                m[V_WASH]      = 1'b1;
                m[V_VERTICAL]  = 1'b1;
                m[V_DEAD_END]  = 1'b1;
            end
            S_ELUTE: begin
                m[V_ELUTE]      = 1'b1;
                m[V_VERTICAL]   = 1'b1;
                m[V_BEAD_TRAP]  = 1'b1;
                m[V_COLLECTION] = 1'b1;
            end
            default: m = '0;
        endcase
        open_mask = m;
    endfunction

    function automatic logic [2:0] pump_pattern(input logic [2:0] p);
        case (p)
            3'd0:    pump_pattern = 3'b110;
            3'd1:    pump_pattern = 3'b010;
            3'd2:    pump_pattern = 3'b011;
            3'd3:    pump_pattern = 3'b001;
            3'd4:    pump_pattern = 3'b101;
            3'd5:    pump_pattern = 3'b100;
            default: pump_pattern = 3'b111;
        endcase
    endfunction

    // Sequencing: timed states, one-cycle DONE, abort overrides any advance.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 16'd1;
        aborted_d = 1'b0;
`ifdef MNACIDPRO_CTRL_WASH2_EN
        wash_pass_d = wash_pass_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_LYSIS;
`ifdef MNACIDPRO_CTRL_WASH2_EN
                    wash_pass_d = 1'b0;
`endif
                end
            end
            S_LYSIS, S_SETTLE, S_WASH, S_ELUTE: begin
                if (cnt_q == state_len(state_q) - 16'd1) begin
                    cnt_d = '0;
                    case (state_q)
                        S_LYSIS:  state_d = S_SETTLE;
                        S_SETTLE: state_d = S_WASH;
`ifdef MNACIDPRO_CTRL_WASH2_EN
                        S_WASH: begin
                            if (!wash_pass_q) begin
                                state_d     = S_SETTLE;
                                wash_pass_d = 1'b1;
                            end else begin
                                state_d = S_ELUTE;
                            end
                        end
`else
                        S_WASH:   state_d = S_ELUTE;
`endif
                        default:  state_d = S_DONE;
                    endcase
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            aborted_d = 1'b1;
        end
    end

    // Pump phase restarts at P0 whenever a pumping state is (re)entered.
    always_comb begin
        phase_d = phase_q;
        div_d   = div_q;
        if (!is_pumping(state_d)) begin
            phase_d = '0;
            div_d   = '0;
        end else if (state_d != state_q) begin
            phase_d = '0;
            div_d   = '0;
        end else if (div_q == PUMP_LAST) begin
            div_d = '0;
            if (pump_dir)
                phase_d = (phase_q == 3'd0) ? 3'd5 : phase_q - 3'd1;
            else
                phase_d = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
        end else begin
            div_d = div_q + 16'd1;
        end
    end

    // Output lines are decoded from next state so they register together with it.
    always_comb begin
        valve_d = ~open_mask(state_d);
        pump_d  = is_pumping(state_d) ? pump_pattern(phase_d) : 3'b111;
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            phase_q   <= '0;
            valve_q   <= '1;
            pump_q    <= 3'b111;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
`ifdef MNACIDPRO_CTRL_WASH2_EN
            wash_pass_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            phase_q   <= phase_d;
            valve_q   <= valve_d;
            pump_q    <= pump_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
`ifdef MNACIDPRO_CTRL_WASH2_EN
            wash_pass_q <= wash_pass_d;
`endif
        end
    end

    assign lysis_ctl      = valve_q[V_LYSIS];
    assign wash_ctl       = valve_q[V_WASH];
    assign elute_ctl      = valve_q[V_ELUTE];
    assign horiz_ctl      = valve_q[V_HORIZ];
    assign vertical_ctl   = valve_q[V_VERTICAL];
    assign loop_exit_ctl  = valve_q[V_LOOP_EXIT];
    assign bead_vtl_ctl   = valve_q[V_BEAD_VTL];
    assign bead_trap_ctl  = valve_q[V_BEAD_TRAP];
    assign collection_ctl = valve_q[V_COLLECTION];
    assign dead_end_ctl   = valve_q[V_DEAD_END];
    assign pump1          = pump_q[2];
    assign pump2          = pump_q[1];
    assign pump3          = pump_q[0];
    assign busy           = busy_q;
    assign done           = done_q;
    assign aborted        = aborted_q;
    assign state          = state_q;

endmodule

// File: tb/tb_mnacidpro_ctrl.sv
// Directed bench for mnacidpro_ctrl: full runs in both pump directions, abort, reset, held start.
module tb_mnacidpro_ctrl;

    localparam int PD = 4;
    localparam int LY = 64;
    localparam int SE = 16;
    localparam int WA = 32;
    localparam int EL = 32;
`ifdef MNACIDPRO_CTRL_WASH2_EN
    localparam int NSEG = 6;
    localparam int SEG_LEN [NSEG] = '{LY, SE, WA, SE, WA, EL};
    localparam int SEG_ST  [NSEG] = '{1, 2, 3, 2, 3, 4};
`else
    localparam int NSEG = 4;
    localparam int SEG_LEN [NSEG] = '{LY, SE, WA, EL};
    localparam int SEG_ST  [NSEG] = '{1, 2, 3, 4};
`endif

    logic clk = 1'b0;
    logic rst_n, start, abort, pump_dir;
    logic lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl, loop_exit_ctl;
    logic bead_vtl_ctl, bead_trap_ctl, collection_ctl, dead_end_ctl;
    logic pump1, pump2, pump3, busy, done, aborted;
    logic [2:0] state;
    logic [9:0] valves;
    logic [2:0] pumps;

    int n_total = 0;
    int n_bad   = 0;
    int done_k;

    always #5 clk = ~clk;

    mnacidpro_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pump_dir(pump_dir),
        .lysis_ctl(lysis_ctl), .wash_ctl(wash_ctl), .elute_ctl(elute_ctl),
        .horiz_ctl(horiz_ctl), .vertical_ctl(vertical_ctl), .loop_exit_ctl(loop_exit_ctl),
        .bead_vtl_ctl(bead_vtl_ctl), .bead_trap_ctl(bead_trap_ctl),
        .collection_ctl(collection_ctl), .dead_end_ctl(dead_end_ctl),
        .pump1(pump1), .pump2(pump2), .pump3(pump3),
        .busy(busy), .done(done), .aborted(aborted), .state(state)
    );

    assign valves = {lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl,
                     loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl, dead_end_ctl};
    assign pumps  = {pump1, pump2, pump3};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Valve order: lysis wash elute horiz vertical loop_exit bead_vtl bead_trap collection dead_end
    function automatic logic [9:0] exp_valves(input int st);
        case (st)
            1:       return 10'b0110101111;
            2:       return 10'b1111010111;
            3:       return 10'b1011011110;
            4:       return 10'b1101011001;
            default: return 10'b1111111111;
        endcase
    endfunction

    function automatic logic [2:0] ptab(input int idx);
        case (idx)
            0:       return 3'b110;
            1:       return 3'b010;
            2:       return 3'b011;
            3:       return 3'b001;
            4:       return 3'b101;
            default: return 3'b100;
        endcase
    endfunction

    // k = cycles since the edge that sampled start; returns state and first cycle of that state.
    task automatic expect_at(input int k, output int st, output int s0);
        int b;
        b  = 1;
        st = 0;
        s0 = 0;
        for (int i = 0; i < NSEG; i++) begin
            if (st == 0 && k >= b && k < b + SEG_LEN[i]) begin
                st = SEG_ST[i];
                s0 = b;
            end
            b += SEG_LEN[i];
        end
        if (st == 0 && k == b) st = 5;
    endtask

    task automatic check_cycle(input int k, input bit dir);
        int st, s0, n, idx;
        logic [2:0] ep;
        expect_at(k, st, s0);
        ep = 3'b111;
        if (st == 1 || st == 3 || st == 4) begin
            n   = ((k - s0) / PD) % 6;
            idx = dir ? (6 - n) % 6 : n;
            ep  = ptab(idx);
        end
        check($sformatf("state k=%0d", k), 32'(state), 32'(st));
        check($sformatf("valves k=%0d", k), 32'(valves), 32'(exp_valves(st)));
        check($sformatf("pumps k=%0d", k), 32'(pumps), 32'(ep));
        check($sformatf("busy k=%0d", k), 32'(busy), 32'(st != 0));
        check($sformatf("done k=%0d", k), 32'(done), 32'(st == 5));
        check($sformatf("aborted k=%0d", k), 32'(aborted), 32'd0);
    endtask

    task automatic begin_run(input bit held);
        start = 1'b1;
        tick();
        if (!held) start = 1'b0;
    endtask

    task automatic run_span(input int from, input int upto, input bit dir);
        for (int k = from; k <= upto; k++) begin
            if (k > from) tick();
            check_cycle(k, dir);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " state"}, 32'(state), 32'd0);
        check({tag, " lines"}, 32'({valves, pumps}), 32'h1FFF);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int settle_k;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; pump_dir = 1'b0;
        done_k = 1;
        for (int i = 0; i < NSEG; i++) done_k += SEG_LEN[i];
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        check("reset aborted", 32'(aborted), 32'd0);
        rst_n = 1'b1;
        tick();
        $display("reset: state=%0d lines=%04h", state, {valves, pumps});

        // Abort while idle is ignored.
        abort = 1'b1;
        tick();
        check_quiet("idle_abort");
        check("idle_abort aborted", 32'(aborted), 32'd0);
        abort = 1'b0;
        $display("idle abort: state=%0d aborted=%0d", state, aborted);

        // Full run, forward pumping.
        pump_dir = 1'b0;
        begin_run(1'b0);
        run_span(1, done_k + 1, 1'b0);
        $display("run fwd: done expected at k=%0d", done_k);

        // Full run, reverse pumping.
        pump_dir = 1'b1;
        begin_run(1'b0);
        run_span(1, done_k + 1, 1'b1);
        $display("run rev: done expected at k=%0d", done_k);

        // Direction change mid-LYSIS takes effect at next step (k=9).
        pump_dir = 1'b0;
        begin_run(1'b0);
        run_span(1, 6, 1'b0);
        pump_dir = 1'b1;
        tick(); check("dirchg k=7", 32'(pumps), 32'(3'b010));
        tick(); check("dirchg k=8", 32'(pumps), 32'(3'b010));
        tick(); check("dirchg k=9", 32'(pumps), 32'(3'b110));
        repeat (4) tick();
        check("dirchg k=13", 32'(pumps), 32'(3'b100));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_quiet("dirchg_abort");
        check("dirchg_abort aborted", 32'(aborted), 32'd1);
        tick();
        $display("dir change: pumps after k=13 step %03b", pumps);

        // Abort on WASH cycle 10.
        pump_dir = 1'b0;
        begin_run(1'b0);
        run_span(1, LY + SE + 10, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_quiet("wash_abort");
        check("wash_abort aborted", 32'(aborted), 32'd1);
        tick();
        check_quiet("wash_abort+1");
        check("wash_abort+1 aborted", 32'(aborted), 32'd0);
        $display("wash abort: state=%0d aborted=%0d", state, aborted);

        // Start held high: one run, rerun one cycle after return to IDLE.
        begin_run(1'b1);
        run_span(1, done_k + 1, 1'b0);
        tick();
        check("held rerun state", 32'(state), 32'd1);
        check("held rerun pumps", 32'(pumps), 32'(3'b110));
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        $display("held start: rerun state=1 checked");

        // Reset during ELUTE discards the run silently.
        settle_k = done_k - EL + 5;
        begin_run(1'b0);
        run_span(1, settle_k, 1'b0);
        rst_n = 1'b0;
        tick();
        check_quiet("elute_reset");
        check("elute_reset aborted", 32'(aborted), 32'd0);
        rst_n = 1'b1;
        tick();
        check_quiet("elute_reset+1");
        check("elute_reset+1 aborted", 32'(aborted), 32'd0);
        $display("elute reset: state=%0d busy=%0d", state, busy);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
